uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that turns the serial `RsRx` line into bytes for the display path. It sits directly upstream of the digit shift register and the ASCII-to-7-segment decoder. Each good frame produces an 8-bit byte on `data_out` plus a single-cycle `received` strobe in the `clk` domain, so downstream logic can clock on `clk` and use `received` as an enable.

## Interface
- `CLOCK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line baud rate.
- `SAMPLING_RATE`, default 16: ticks per bit. Must be even and ≥ 4.
- `clk`  in  1: system clock. One clock domain; all logic is on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `RsRx`  in  1: asynchronous serial input, idle high, 8N1 framing, LSB first.
- `data_out`  out  8: last good byte; held until the next good frame.
- `receiving`  out  1: high while a frame is in progress (states START, DATA, STOP).
- `received`  out  1: one-`clk` pulse when `data_out` is updated.
- `frame_err`  out  1: one-`clk` pulse on a bad stop bit. Present only with `UART_RX_FRAME_ERR_EN`.

## Operation
- Synchronizer: 2-flop synchronizer on `RsRx`, both flops reset to 1. All decisions use the second flop, `rx_s`.
- Tick generator: `TICK_DIV = CLOCK_FREQ / (BAUD_RATE * SAMPLING_RATE)` (integer truncation; 54 for the defaults).
  - Counter runs 0..TICK_DIV-1 and emits `tick` when it equals TICK_DIV-1.
  - Counter is cleared when leaving IDLE.
- Tick counter `tcnt`: counts ticks within a bit. Bit index `bcnt` runs 0..7.
- State machine (reset state IDLE):
  - IDLE: when `rx_s == 0`, go to START and clear the divider and `tcnt`.
  - START: on the tick that makes `tcnt == SAMPLING_RATE/2 - 1`, sample `rx_s` (mid start bit).
    - If 0: go to DATA, clear `tcnt` and `bcnt`.
    - If 1: treat as a glitch and return to IDLE with no output activity.
  - DATA: on the tick that makes `tcnt == SAMPLING_RATE - 1`, shift `rx_s` into bit `bcnt` of the shift register (LSB first) and clear `tcnt`.
    - After bit 7, go to STOP.
  - STOP: on the tick that makes `tcnt == SAMPLING_RATE - 1`, sample the stop bit.
    - If 1: load `data_out` from the shift register, pulse `received`, go to IDLE.
    - If 0: handled per Configuration, then go to IDLE.
- Back-to-back frames: a start edge seen in IDLE right after STOP is accepted. No idle gap is required.
- Reset values: `data_out = 8'h00`, `receiving = 0`, `received = 0`, `frame_err = 0`, state IDLE, all counters 0.
- Reset mid-frame: the partial frame is discarded, no `received`, `data_out` keeps `8'h00`. The next falling edge after reset release starts a new frame.

## Timing
- `received`, `frame_err` and `receiving` are registered outputs.
- `received` is high for exactly one cycle: the cycle after the stop-sample tick.
- `data_out` changes on the same edge that raises `received`.
- Bit period is `SAMPLING_RATE * TICK_DIV` clocks (864 at defaults).
- Latency from the `RsRx` falling edge to the `received` rise: 2 (synchronizer) + 1 (IDLE exit) + `(SAMPLING_RATE/2 + 9*SAMPLING_RATE) * TICK_DIV` + 1 clocks. At defaults that is 8212 clocks. The bench allows ±2.
- `receiving` rises 3 clocks after the falling edge.
  - It falls with the `received` / `frame_err` pulse.
  - On a glitch abort, it falls one clock after the start-sample tick.

## Configuration
- `UART_RX_FRAME_ERR_EN` defined:
  - The `frame_err` port exists.
  - A 0 stop bit pulses `frame_err` for one cycle in place of `received`.
  - `data_out` is not updated.
- `UART_RX_FRAME_ERR_EN` undefined:
  - No `frame_err` port.
  - The stop-bit value is ignored and every frame that reaches STOP loads `data_out` and pulses `received`.

## Test plan
- Reset, then an idle line for 2000 clocks -> `data_out == 8'h00`, `receiving == 0`, no `received` pulse.
- Send 8N1 byte `0x41` at 864 clocks/bit -> exactly one `received` pulse about 8212 clocks after the start edge, `data_out == 8'h41`.
- Low glitch of 200 clocks on `RsRx` -> `receiving` pulses briefly, no `received`, `data_out` unchanged.
- Send `0x55` then `0xAA` with no idle gap -> two `received` pulses 8640 clocks apart, `data_out` reads `0x55` then `0xAA`.
- Send `0x33` with the stop bit forced to 0:
  - With `UART_RX_FRAME_ERR_EN`: one `frame_err` pulse, no `received`, `data_out` keeps its prior value.
  - Without it: `received` pulses and `data_out == 8'h33`.
- Assert `rst_n = 0` for 1 cycle during bit 4 of `0x7E`, then send `0x31` -> no pulse for the aborted frame, `data_out == 8'h31` after the second frame.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver.
// RsRx is double-flopped into rx_s. A free-running divider produces one tick
// every TICK_DIV clocks. The start bit is sampled after SAMPLING_RATE/2 ticks,
// and each data bit and the stop bit after SAMPLING_RATE further ticks.
// Optional feature macro: UART_RX_FRAME_ERR_EN. When it is defined, the
// frame_err port exists and a low stop bit pulses frame_err instead of
// loading data_out.
module uart_rx #(
    parameter int CLOCK_FREQ    = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int SAMPLING_RATE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RsRx,
    output logic [7:0] data_out,
    output logic       receiving,
    output logic       received
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * SAMPLING_RATE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TCNT_W   = $clog2(SAMPLING_RATE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(SAMPLING_RATE / 2 - 1);
    localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(SAMPLING_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic              rx_m;
    logic              rx_s;
    logic [DIV_W-1:0]  div;
    logic              tick;
    logic [TCNT_W-1:0] tcnt;
    logic [2:0]        bcnt;
    logic [7:0]        shift;
    logic              start_det;

    // The frame begins on the first low level seen while idle.
    always_comb begin
        start_det = (state == IDLE) && !rx_s;
    end

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RsRx;
            rx_s <= rx_m;
        end
    end

    // Tick divider, restarted at the start edge so that samples stay aligned to the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (start_det) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (div == DIV_LAST) begin
            div  <= '0;
            tick <= 1'b1;
        end else begin
            div  <= div + 1'b1;
            tick <= 1'b0;
        end
    end

    // Frame state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shift     <= '0;
            data_out  <= '0;
            receiving <= 1'b0;
            received  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            received  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        tcnt      <= '0;
                        receiving <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == HALF_LAST) begin
                            tcnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                bcnt  <= '0;
                            end else begin
                                // A start bit that is high in the middle is a glitch.
                                state     <= IDLE;
                                receiving <= 1'b0;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt == BIT_LAST) begin
                            tcnt        <= '0;
                            shift[bcnt] <= rx_s;
                            if (bcnt == 3'd7) begin
                                state <= STOP;
                                bcnt  <= '0;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tcnt == BIT_LAST) begin
                            tcnt      <= '0;
                            state     <= IDLE;
                            receiving <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                            if (rx_s) begin
                                data_out <= shift;
                                received <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
`else
                            data_out <= shift;
                            received <= 1'b1;
`endif
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    receiving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at the default parameters (864 clocks per bit).
// The frame table holds fixed and $urandom entries. Their expected outcomes
// come from frame-level rules: a frame is accepted unless frame-error
// checking is built in and the stop bit is 0. Hand-written sequences cover
// idle, glitch and mid-frame reset.
module tb_uart_rx;

    localparam int BIT_CLKS = 864;
    localparam int LAT      = 8212;
    localparam int NVEC     = 7;

`ifdef UART_RX_FRAME_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       RsRx;
    logic [7:0] data_out;
    logic       receiving;
    logic       received;
    logic       fe_w;

    uart_rx #(
        .CLOCK_FREQ   (100_000_000),
        .BAUD_RATE    (115200),
        .SAMPLING_RATE(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RsRx     (RsRx),
        .data_out (data_out),
        .receiving(receiving),
        .received (received)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(fe_w)
`endif
    );

`ifndef UART_RX_FRAME_ERR_EN
    assign fe_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_rcv;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    ev_t  evq[$];
    int   rise_q[$];
    int   bad_width = 0;
    int   bad_change = 0;
    logic prev_received = 1'b0;
    logic prev_receiving = 1'b0;
    logic prev_rst = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int checks = 0;
    int failures = 0;

    // Output monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (received || fe_w) evq.push_back('{cyc: cyc, ferr: fe_w, data: data_out});
        if (receiving && !prev_receiving) rise_q.push_back(cyc);
        if (received && prev_received) bad_width++;
        if (prev_rst && (data_out !== prev_data) && !received) bad_change++;
        prev_received  = received;
        prev_receiving = receiving;
        prev_data      = data_out;
        prev_rst       = rst_n;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Waits n rising edges and leaves the phase 1 time unit after the edge.
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                              output int t0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            RsRx = bits[i];
            wait_cyc(BIT_CLKS);
        end
        RsRx = 1'b1;
        wait_cyc(gap);
    endtask

    vec_t       tbl[NVEC];
    logic [7:0] model_data;
    int         t0;
    int         prev_ev_cyc;
    ev_t        ev;

    initial begin
        // Frame table: the first four entries are fixed, the rest are random with valid stop bits.
        tbl[0] = '{data: 8'h41, stop: 1'b1, gap: 300,  exp_rcv: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
        tbl[1] = '{data: 8'h55, stop: 1'b1, gap: 0,    exp_rcv: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
        tbl[2] = '{data: 8'hAA, stop: 1'b1, gap: 300,  exp_rcv: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
        tbl[3] = '{data: 8'h33, stop: 1'b0, gap: 1000, exp_rcv: 1'b0, exp_ferr: 1'b0, exp_data: 8'h00};
        for (int i = 4; i < NVEC; i++) begin
            tbl[i].data = 8'($urandom);
            tbl[i].stop = 1'b1;
            tbl[i].gap  = int'($urandom_range(0, 400));
        end
        model_data = 8'h00;
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].exp_rcv  = tbl[i].stop || !FE;
            tbl[i].exp_ferr = !tbl[i].stop && FE;
            if (tbl[i].exp_rcv) model_data = tbl[i].data;
            tbl[i].exp_data = model_data;
        end

        // Reset state.
        rst_n = 1'b0;
        RsRx  = 1'b1;
        @(posedge clk);
        #1;
        wait_cyc(4);
        rst_n = 1'b1;
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_receiving", int'(receiving), 0);
        chk("reset_received", int'(received), 0);

        // Idle line.
        wait_cyc(2000);
        chk("idle_events", evq.size(), 0);
        chk("idle_data_out", int'(data_out), 0);
        chk("idle_receiving", int'(receiving), 0);

        // Table-driven frames.
        model_data  = 8'h00;
        prev_ev_cyc = 0;
        for (int i = 0; i < NVEC; i++) begin
            evq.delete();
            rise_q.delete();
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, t0);
            chk($sformatf("v%0d_events", i), evq.size(), 1);
            chk($sformatf("v%0d_data_out", i), int'(data_out), int'(tbl[i].exp_data));
            chk($sformatf("v%0d_receiving_end", i), int'(receiving), 0);
            if (rise_q.size() > 0)
                chk($sformatf("v%0d_receiving_rise", i), rise_q[0] - t0, 3);
            else
                chk($sformatf("v%0d_receiving_rise_count", i), 0, 1);
            if (evq.size() == 1) begin
                ev = evq.pop_front();
                chk($sformatf("v%0d_kind_ferr", i), int'(ev.ferr), int'(tbl[i].exp_ferr));
                chk_rng($sformatf("v%0d_latency", i), ev.cyc - t0, LAT - 2, LAT + 2);
                if (tbl[i].exp_rcv)
                    chk($sformatf("v%0d_event_data", i), int'(ev.data), int'(tbl[i].exp_data));
                if (i > 0 && tbl[i-1].gap == 0)
                    chk_rng($sformatf("v%0d_spacing", i), ev.cyc - prev_ev_cyc,
                            10 * BIT_CLKS - 2, 10 * BIT_CLKS + 2);
                prev_ev_cyc = ev.cyc;
            end
            model_data = tbl[i].exp_data;
        end

        // A 200-clock low glitch: receiving pulses, nothing is delivered.
        evq.delete();
        rise_q.delete();
        RsRx = 1'b0;
        wait_cyc(200);
        RsRx = 1'b1;
        wait_cyc(1000);
        chk("glitch_events", evq.size(), 0);
        chk("glitch_receiving_pulses", rise_q.size(), 1);
        chk("glitch_receiving_end", int'(receiving), 0);
        chk("glitch_data_out", int'(data_out), int'(model_data));

        // One-cycle reset in the middle of bit 4 of 0x7E, then 0x31.
        evq.delete();
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h7E, 1'b0};
            for (int i = 0; i < 5; i++) begin
                RsRx = bits[i];
                wait_cyc(BIT_CLKS);
            end
            RsRx = bits[5];
            wait_cyc(BIT_CLKS / 2);
        end
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        RsRx  = 1'b1;
        wait_cyc(2000);
        chk("midrst_events", evq.size(), 0);
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_receiving", int'(receiving), 0);
        send_frame(8'h31, 1'b1, 300, t0);
        chk("after_rst_events", evq.size(), 1);
        if (evq.size() == 1) begin
            ev = evq.pop_front();
            chk_rng("after_rst_latency", ev.cyc - t0, LAT - 2, LAT + 2);
            chk("after_rst_event_data", int'(ev.data), 8'h31);
        end
        chk("after_rst_data_out", int'(data_out), 8'h31);

        // Stream-wide properties seen by the monitor.
        chk("received_single_cycle_violations", bad_width, 0);
        chk("data_out_change_without_received", bad_change, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
